intr_ctrl: RTL and testbench

- Interrupt status/aggregation stage for the controller's CSR interrupt block.
- Detects per-source events (level or rising edge), applies software force and enable masks, and stores the interrupt status bits.
- Supports W1C clears from the CSR write path.
- Combines the signalled status bits into one registered irq_o, with an optional programmable hold-off that limits the interrupt rate toward the host.

---
 rtl/intr_ctrl.sv | 134 +++++++++++++
 tb/tb_intr_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// intr_ctrl -- interrupt status/aggregation stage of the CSR interrupt block.
//
// Detects per-source events (level or rising edge), applies software force and
// the status-enable mask, and holds the W1C status bits. Status bits gated by
// the signal-enable mask are combined into one registered interrupt to the host.
//
// Build option: define INTR_CTRL_HOLDOFF_EN to build the programmable hold-off
// that keeps irq_o low for holdoff_i + 2 cycles between assertions. Without it,
// the minimum low time is 1 cycle, holdoff_i is ignored and holdoff_active_o is 0.
//
// Parameters:
//   NUM_IRQ    number of interrupt sources
//   EDGE_MASK  bit i = 1: source i is rising-edge detected, 0: level detected
//   HOLDOFF_W  width of holdoff_i and of the hold-off counter
//
// Ports:
//   clk_i             clock
//   rst_i             asynchronous active-high reset
//   irq_src_i         raw interrupt sources
//   irq_force_i       single-cycle force pulses (CSR FORCE write)
//   sts_ena_i         per-source status enable
//   sig_ena_i         per-source signal enable
//   clr_i             W1C data for the STATUS register
//   clr_we_i          STATUS register write strobe
//   holdoff_i         hold-off length in cycles (sampled when irq_o drops)
//   sts_o             interrupt status register
//   irq_o             registered aggregated interrupt
//   holdoff_active_o  high while the hold-off counter runs
module intr_ctrl #(
  parameter int unsigned          NUM_IRQ   = 8,
  parameter logic [NUM_IRQ-1:0]   EDGE_MASK = '0,
  parameter int unsigned          HOLDOFF_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_IRQ-1:0]   irq_src_i,
  input  logic [NUM_IRQ-1:0]   irq_force_i,
  input  logic [NUM_IRQ-1:0]   sts_ena_i,
  input  logic [NUM_IRQ-1:0]   sig_ena_i,
  input  logic [NUM_IRQ-1:0]   clr_i,
  input  logic                 clr_we_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  output logic [NUM_IRQ-1:0]   sts_o,
  output logic                 irq_o,
  output logic                 holdoff_active_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] src_q;
  logic [NUM_IRQ-1:0] sts_q, sts_d;
  logic [NUM_IRQ-1:0] ev, set, clr;
  logic               pending;

  // Edge sources fire only on a 0->1 transition; level sources fire while high.
  assign ev  = (irq_src_i & ~EDGE_MASK) | (irq_src_i & EDGE_MASK & ~src_q);
  assign set = (ev | irq_force_i) & sts_ena_i;
  assign clr = {NUM_IRQ{clr_we_i}} & clr_i;
  // Set wins over a simultaneous W1C clear.
  assign sts_d = set | (sts_q & ~clr);

  assign pending = |(sts_q & sig_ena_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q   <= '0;
      sts_q   <= '0;
      state_q <= IDLE;
    end else begin
      src_q   <= irq_src_i;
      sts_q   <= sts_d;
      state_q <= state_d;
    end
  end

  assign sts_o = sts_q;
  assign irq_o = (state_q == ASSERT);

`ifdef INTR_CTRL_HOLDOFF_EN
  logic [HOLDOFF_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pending) state_d = ASSERT;
      end
      ASSERT: begin
        if (!pending) begin
          state_d = HOLDOFF;
          cnt_d   = holdoff_i;
        end
      end
      HOLDOFF: begin
        // Pending is ignored here; the counter only ever decrements.
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign holdoff_active_o = (state_q == HOLDOFF);
`else
  logic unused_holdoff;
  assign unused_holdoff = ^holdoff_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending)  state_d = ASSERT;
      ASSERT:  if (!pending) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign holdoff_active_o = 1'b0;
`endif

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl (NUM_IRQ = 4, EDGE_MASK = 4'b0010).
// A cycle-level behavioural model tracks the expected status bits, the
// interrupt line and the remaining quiet time after each deassertion.
module tb_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_src, irq_force, sts_ena, sig_ena, clr;
  logic        clr_we;
  logic [15:0] holdoff;
  logic [3:0]  sts;
  logic        irq, hact;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [3:0] edge_mask = 4'b0010;
  logic [3:0] m_sts, m_src;
  logic       m_irq;
  int         m_quiet;

  always #5 clk = ~clk;

  intr_ctrl #(
    .NUM_IRQ   (4),
    .EDGE_MASK (4'b0010),
    .HOLDOFF_W (16)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .irq_src_i        (irq_src),
    .irq_force_i      (irq_force),
    .sts_ena_i        (sts_ena),
    .sig_ena_i        (sig_ena),
    .clr_i            (clr),
    .clr_we_i         (clr_we),
    .holdoff_i        (holdoff),
    .sts_o            (sts),
    .irq_o            (irq),
    .holdoff_active_o (hact)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sts   = '0;
    m_src   = '0;
    m_irq   = 1'b0;
    m_quiet = 0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_step();
    logic [3:0] nsts;
    logic       ev, pend;
    pend = |(m_sts & sig_ena);
    for (int i = 0; i < 4; i++) begin
      ev = edge_mask[i] ? (irq_src[i] && !m_src[i]) : irq_src[i];
      if ((ev || irq_force[i]) && sts_ena[i]) nsts[i] = 1'b1;
      else if (clr_we && clr[i])              nsts[i] = 1'b0;
      else                                    nsts[i] = m_sts[i];
    end
    if (m_irq) begin
      if (!pend) begin
        m_irq = 1'b0;
`ifdef INTR_CTRL_HOLDOFF_EN
        m_quiet = int'(holdoff) + 1;
`else
        m_quiet = 0;
`endif
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else if (pend) begin
      m_irq = 1'b1;
    end
    m_src = irq_src;
    m_sts = nsts;
  endtask

  task automatic check_outputs(input string where);
    check({where, ".sts"}, 32'(sts), 32'(m_sts));
    check({where, ".irq"}, 32'(irq), 32'(m_irq));
    check({where, ".holdoff_active"}, 32'(hact), 32'(m_quiet > 0));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    check_outputs("cyc");
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs("rst_async");
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    irq_src   = '0;
    irq_force = '0;
    clr       = '0;
    clr_we    = 1'b0;
  endtask

  // Force bit 0, let irq rise, then W1C it so irq falls into hold-off.
  task automatic raise_and_clear(input logic [3:0] late_force);
    irq_force = 4'h1; cycle();
    irq_force = '0;   cycle(); cycle();
    clr_we = 1'b1; clr = 4'h1; cycle();
    clr_we = 1'b0; clr = '0; irq_force = late_force; cycle();
    irq_force = '0;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    idle_inputs();
    sts_ena = 4'hF;
    sig_ena = 4'hF;
    holdoff = '0;
    model_reset();
    #2;
    check_outputs("rst_init");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset with all status set and irq high
    irq_force = 4'hF; cycle();
    irq_force = '0;   cycle(); cycle();
    check("pre_reset_irq", 32'(irq), 32'd1);
    do_reset();
    repeat (3) cycle();

    // Level path and set/clear collision
    irq_src = 4'h1; cycle();
    irq_src = '0;   repeat (3) cycle();
    irq_src = 4'h1; clr_we = 1'b1; clr = 4'h1; repeat (3) cycle();
    irq_src = '0; cycle();
    clr_we = 1'b0; clr = '0; repeat (3) cycle();

    // Edge path: held high, cleared, re-rise
    irq_src = 4'h2; repeat (3) cycle();
    clr_we = 1'b1; clr = 4'h2; cycle();
    clr_we = 1'b0; clr = '0; repeat (6) cycle();
    irq_src = '0; repeat (3) cycle();
    irq_src = 4'h2; cycle();
    irq_src = '0; clr_we = 1'b1; clr = 4'hF; cycle();
    clr_we = 1'b0; clr = '0; repeat (8) cycle();

    // Hold-off of 3 with a force landing just after the clear; then 0
    holdoff = 16'd3;
    raise_and_clear(4'h4);
    repeat (10) cycle();
    clr_we = 1'b1; clr = 4'hF; cycle();
    clr_we = 1'b0; clr = '0; repeat (8) cycle();
    holdoff = 16'd0;
    raise_and_clear(4'h4);
    repeat (6) cycle();
    clr_we = 1'b1; clr = 4'hF; cycle();
    clr_we = 1'b0; clr = '0; repeat (4) cycle();

    // Masks
    sts_ena = '0; irq_force = 4'hF; cycle();
    irq_force = '0; cycle();
    sts_ena = 4'hF; sig_ena = '0; irq_force = 4'h8; cycle();
    irq_force = '0; repeat (2) cycle();
    sig_ena = 4'h8; repeat (2) cycle();
    sig_ena = '0; repeat (2) cycle();   // signal-enable drop acts like a clear
    sig_ena = 4'hF; clr_we = 1'b1; clr = 4'hF; cycle();
    clr_we = 1'b0; clr = '0; repeat (4) cycle();

    // Reset in the middle of a hold-off
    holdoff = 16'd20;
    raise_and_clear(4'h0);
    cycle();
    do_reset();
    repeat (3) cycle();

    // Maximum hold-off: counter must run down without wrapping
    holdoff = 16'hFFFF;
    raise_and_clear(4'h4);
    guard = 0;
    while (m_quiet > 0 && guard < 70000) begin
      cycle();
      guard++;
    end
    check("holdoff_max_bound", 32'(guard < 70000), 32'd1);
    repeat (3) cycle();
    clr_we = 1'b1; clr = 4'hF; cycle();
    idle_inputs(); repeat (3) cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      irq_src   = 4'($urandom);
      irq_force = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      clr_we    = ($urandom_range(0, 3) == 0);
      clr       = 4'($urandom);
      sts_ena   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
      sig_ena   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
      holdoff   = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 399) == 0) do_reset();
      else                             cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
